// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte buffer: frame-done synchroniser feeding a FWFT FIFO.
// Optional UART_RX_FIFO_CR_DROP_EN: discard 8'h0D bytes at the push point.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  logic          s1, s2, s3, armed;
  logic [1:0]    primed;
  logic          frame_evt, push_req, do_push, do_pop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_next;
  logic [7:0]    mem [DEPTH];

  // primed[1] marks that s2 holds a genuinely sampled rx_done, so a level
  // already high across reset release cannot arm the edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      armed  <= 1'b0;
      primed <= 2'b00;
    end else begin
      s1     <= rx_done;
      s2     <= s1;
      s3     <= s2;
      primed <= {primed[0], 1'b1};
      if (primed[1] && !s2)
        armed <= 1'b1;
    end
  end

  assign frame_evt = s2 & ~s3 & armed;

`ifdef UART_RX_FIFO_CR_DROP_EN
  assign push_req = frame_evt && (rx_data != 8'h0D);
`else
  assign push_req = frame_evt;
`endif

  assign do_pop     = rd_en & ~empty;
  assign do_push    = push_req & (~full | do_pop);
  assign count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));
      if (push_req && full && !do_pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= rx_data;
  end

  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo against a queue reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset, rx_done, rd_en;
  logic [7:0]    rx_data;
  logic [7:0]    rd_data;
  logic          empty, full, overflow;
  logic [AW:0]   count;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         land;
  } pend_t;

  pend_t      pend[$];
  logic [7:0] model_q[$];
  logic       model_ovf = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         rd_mode = 0;
  int         max_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare visible state to the model, then advance the model by the coming edge.
  always @(negedge clk) begin
    logic       pop, push, accept;
    logic [7:0] b;
    if (reset !== 1'bx) begin
      check("empty",    int'(empty),    int'(model_q.size() == 0));
      check("full",     int'(full),     int'(model_q.size() == DEPTH));
      check("count",    int'(count),    model_q.size());
      check("overflow", int'(overflow), int'(model_ovf));
      check("rd_data",  int'(rd_data),  (model_q.size() == 0) ? 0 : int'(model_q[0]));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (reset) begin
        model_q.delete();
        pend.delete();
        model_ovf = 1'b0;
      end else begin
        pop  = rd_en && (model_q.size() > 0);
        push = (pend.size() > 0) && (pend[0].land == cyc + 1);
        b    = 8'h00;
        if (push) begin
          b = pend[0].b;
          void'(pend.pop_front());
`ifdef UART_RX_FIFO_CR_DROP_EN
          if (b == 8'h0D) push = 1'b0;
`endif
        end
        accept = push && (model_q.size() < DEPTH || pop);
        if (push && !accept) model_ovf = 1'b1;
        if (pop) void'(model_q.pop_front());
        if (accept) model_q.push_back(b);
      end
    end
  end

  initial begin
    rd_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_en = (rd_mode == 1) ? 1'b1 : (rd_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input int low_gap);
    pend_t p;
    rx_data = b;
    rx_done = 1'b1;
    p.b = b;
    p.land = cyc + 3;
    pend.push_back(p);
    tick(2);
    rx_done = 1'b0;
    tick(low_gap);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'h00;
    tick(3);
    // Level already high at release must never be written.
    reset = 1'b0;
    tick(10);
    rx_done = 1'b0;
    tick(6);
    frame(8'h41, 4);
    rd_mode = 1;
    tick(3);
    rd_mode = 0;

    // Fill to full, overflow, then drain in order.
    for (int i = 1; i <= 16; i++) frame(8'(i), 2);
    tick(4);
    frame(8'h55, 4);
    check("ovf_sticky", int'(overflow), 1);
    rd_mode = 1;
    tick(20);
    rd_mode = 0;
    check("ovf_after_drain", int'(overflow), 1);
    do_reset(1);
    tick(6);

    // Continuous reads while frames stream in.
    rd_mode = 1;
    max_cnt = 0;
    for (int i = 0; i < 4; i++) frame(8'hA0 + 8'(i), 2);
    tick(4);
    check("max_count_streaming", max_cnt, 1);
    rd_mode = 0;

    // Full FIFO, push coincides with a pop.
    for (int i = 0; i < 16; i++) frame(8'hB0 + 8'(i), 2);
    tick(3);
    rd_mode = 1;
    frame(8'hC5, 4);
    rd_mode = 0;
    rd_mode = 1;
    tick(20);
    rd_mode = 0;

    // Reset between rx_done rise and the write edge.
    frame(8'h77, 0);
    do_reset(1);
    rx_done = 1'b0;
    tick(6);

    // CR handling.
    frame(8'h48, 2);
    frame(8'h0D, 2);
    frame(8'h49, 4);
`ifdef UART_RX_FIFO_CR_DROP_EN
    check("cr_count", int'(count), 2);
`else
    check("cr_count", int'(count), 3);
`endif
    rd_mode = 1;
    tick(6);
    rd_mode = 0;

    // Random traffic.
    rd_mode = 2;
    for (int i = 0; i < 200; i++) begin
      frame(8'($urandom_range(0, 255)), $urandom_range(2, 6));
      if (i == 100) rd_mode = 0;
      if (i == 140) rd_mode = 2;
    end
    tick(6);
    rd_mode = 1;
    tick(30);
    rd_mode = 0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
